// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB latch with load-wait, load/LUI/link result formatting,
// register file write port, hazard pending indication, retire counter and sticky halt.
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              mem_regwr,
  input  logic [ADDR_W-1:0] mem_wsel,
  input  logic [1:0]        mem_src,
  input  logic [DATA_W-1:0] mem_alu,
  input  logic [DATA_W-1:0] mem_pc4,
  input  logic [15:0]       mem_imm16,
  input  logic [1:0]        mem_ldtype,
  input  logic              mem_ldsigned,
  input  logic [1:0]        mem_byteoff,
  input  logic              mem_halt,
  input  logic              dload_valid,
  input  logic [DATA_W-1:0] dload,
  output logic              rf_WEN,
  output logic [ADDR_W-1:0] rf_wsel,
  output logic [DATA_W-1:0] rf_wdat,
  output logic              fwd_pending,
  output logic [ADDR_W-1:0] fwd_sel,
  output logic              halt,
  output logic [31:0]       retired
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    VALID     = 2'd1,
    WAIT_LOAD = 2'd2,
    HALTED    = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] ZERO_SEL = '0;

  state_e              state_q, state_d;
  logic                regwr_q, regwr_d;
  logic [ADDR_W-1:0]   wsel_q, wsel_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          ldtype_q, ldtype_d;
  logic                ldsigned_q, ldsigned_d;
  logic [1:0]          byteoff_q, byteoff_d;
  logic [31:0]         retired_q, retired_d;
  logic                accept;
  logic [1:0]          ret_inc;

  // Select the addressed half/byte lane and extend it; ldtype 11 falls back to word.
  function automatic logic [31:0] fmt_load(input logic [1:0] ldtype, input logic sgn,
                                           input logic [1:0] off, input logic [31:0] w);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = off[1] ? w[31:16] : w[15:0];
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = w[7:0];
    endcase
    case (ldtype)
      2'b01:   r = {{16{sgn & h[15]}}, h};
      2'b10:   r = {{24{sgn & b[7]}}, b};
      default: r = w;
    endcase
    return r;
  endfunction

  assign mem_ready   = (state_q == EMPTY) || (state_q == VALID);
  assign accept      = mem_valid && mem_ready;
  assign rf_WEN      = (state_q == VALID) && regwr_q && (wsel_q != ZERO_SEL);
  assign rf_wsel     = wsel_q;
  assign rf_wdat     = data_q;
  assign fwd_pending = (state_q == WAIT_LOAD) && regwr_q && (wsel_q != ZERO_SEL);
  assign fwd_sel     = wsel_q;
  assign halt        = (state_q == HALTED);
  assign retired     = retired_q;

  // Next-state, latch update and retire accounting.
  always_comb begin
    state_d    = state_q;
    regwr_d    = regwr_q;
    wsel_d     = wsel_q;
    data_d     = data_q;
    ldtype_d   = ldtype_q;
    ldsigned_d = ldsigned_q;
    byteoff_d  = byteoff_q;
    case (state_q)
      EMPTY, VALID: begin
        if (accept) begin
          if (mem_halt) begin
            state_d = HALTED;
            regwr_d = 1'b0;
          end else if (mem_src == 2'b01) begin
            state_d    = WAIT_LOAD;
            regwr_d    = mem_regwr;
            wsel_d     = mem_wsel;
            ldtype_d   = mem_ldtype;
            ldsigned_d = mem_ldsigned;
            byteoff_d  = mem_byteoff;
          end else begin
            state_d = VALID;
            regwr_d = mem_regwr;
            wsel_d  = mem_wsel;
            case (mem_src)
              2'b10:   data_d = mem_pc4;
              2'b11:   data_d = {mem_imm16, 16'h0000};
              default: data_d = mem_alu;
            endcase
          end
        end else begin
          state_d = EMPTY;
        end
      end
      WAIT_LOAD: begin
        if (dload_valid) begin
          state_d = VALID;
          data_d  = fmt_load(ldtype_q, ldsigned_q, byteoff_q, dload);
        end else begin
          state_d = WAIT_LOAD;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = EMPTY;
    endcase
    // A VALID entry retiring on the same edge a halt is accepted counts twice.
    ret_inc   = {1'b0, (state_q == VALID)} +
                {1'b0, (state_d == HALTED) && (state_q != HALTED)};
    retired_d = retired_q + {30'd0, ret_inc};
  end

  // State and latch registers with asynchronous clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= EMPTY;
      regwr_q    <= 1'b0;
      wsel_q     <= '0;
      data_q     <= '0;
      ldtype_q   <= 2'b00;
      ldsigned_q <= 1'b0;
      byteoff_q  <= 2'b00;
      retired_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      regwr_q    <= regwr_d;
      wsel_q     <= wsel_d;
      data_q     <= data_d;
      ldtype_q   <= ldtype_d;
      ldsigned_q <= ldsigned_d;
      byteoff_q  <= byteoff_d;
      retired_q  <= retired_d;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage; expected values are hand-computed.
module tb_writeback_stage;

  logic        CLK, nRST;
  logic        mem_valid, mem_ready, mem_regwr, mem_ldsigned, mem_halt;
  logic [4:0]  mem_wsel;
  logic [1:0]  mem_src, mem_ldtype, mem_byteoff;
  logic [31:0] mem_alu, mem_pc4, dload;
  logic [15:0] mem_imm16;
  logic        dload_valid, rf_WEN, fwd_pending, halt;
  logic [4:0]  rf_wsel, fwd_sel;
  logic [31:0] rf_wdat, retired;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ret  = 0;

  writeback_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK(CLK), .nRST(nRST),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_regwr(mem_regwr),
    .mem_wsel(mem_wsel), .mem_src(mem_src), .mem_alu(mem_alu), .mem_pc4(mem_pc4),
    .mem_imm16(mem_imm16), .mem_ldtype(mem_ldtype), .mem_ldsigned(mem_ldsigned),
    .mem_byteoff(mem_byteoff), .mem_halt(mem_halt),
    .dload_valid(dload_valid), .dload(dload),
    .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .fwd_pending(fwd_pending), .fwd_sel(fwd_sel), .halt(halt), .retired(retired)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rf_WEN"},      32'(rf_WEN), 32'd0);
    check({tag, " rf_wsel"},     32'(rf_wsel), 32'd0);
    check({tag, " rf_wdat"},     rf_wdat, 32'd0);
    check({tag, " fwd_pending"}, 32'(fwd_pending), 32'd0);
    check({tag, " fwd_sel"},     32'(fwd_sel), 32'd0);
    check({tag, " halt"},        32'(halt), 32'd0);
    check({tag, " retired"},     retired, 32'd0);
    check({tag, " mem_ready"},   32'(mem_ready), 32'd1);
  endtask

  // Non-load instruction: accept, then check the write port the following cycle.
  task automatic simple_op(input string tag, input logic [1:0] src, input logic [4:0] wsel,
                           input logic [31:0] alu, input logic [31:0] pc4,
                           input logic [15:0] imm, input logic exp_wen,
                           input logic [31:0] exp_dat);
    mem_valid = 1'b1; mem_regwr = 1'b1; mem_src = src; mem_wsel = wsel;
    mem_alu = alu; mem_pc4 = pc4; mem_imm16 = imm; mem_halt = 1'b0;
    step();
    mem_valid = 1'b0;
    check({tag, " wen"},  32'(rf_WEN), 32'(exp_wen));
    check({tag, " wsel"}, 32'(rf_wsel), 32'(wsel));
    check({tag, " wdat"}, rf_wdat, exp_dat);
    step();
    exp_ret++;
    check({tag, " retired"}, retired, 32'(exp_ret));
  endtask

  // Load with dload_valid presented in the cycle right after acceptance.
  task automatic load_op(input string tag, input logic [1:0] ldtype, input logic sgn,
                         input logic [1:0] off, input logic [31:0] word,
                         input logic [31:0] exp_dat);
    mem_valid = 1'b1; mem_regwr = 1'b1; mem_src = 2'b01; mem_wsel = 5'd12;
    mem_ldtype = ldtype; mem_ldsigned = sgn; mem_byteoff = off; mem_halt = 1'b0;
    step();
    mem_valid = 1'b0; dload_valid = 1'b1; dload = word;
    step();
    dload_valid = 1'b0;
    check({tag, " wen"},  32'(rf_WEN), 32'd1);
    check({tag, " wdat"}, rf_wdat, exp_dat);
    step();
    exp_ret++;
  endtask

  initial begin
    nRST = 1'b0; mem_valid = 1'b0; mem_regwr = 1'b0; mem_wsel = 5'd0; mem_src = 2'b00;
    mem_alu = 32'd0; mem_pc4 = 32'd0; mem_imm16 = 16'd0; mem_ldtype = 2'b00;
    mem_ldsigned = 1'b0; mem_byteoff = 2'b00; mem_halt = 1'b0;
    dload_valid = 1'b0; dload = 32'd0;
    #1;
    check_reset_outputs("reset");
    @(negedge CLK);
    nRST = 1'b1;

    // Back-to-back ALU writes
    mem_valid = 1'b1; mem_regwr = 1'b1; mem_src = 2'b00; mem_wsel = 5'd3; mem_alu = 32'h11;
    step();
    check("b2b first wen",  32'(rf_WEN), 32'd1);
    check("b2b first wsel", 32'(rf_wsel), 32'd3);
    check("b2b first wdat", rf_wdat, 32'h11);
    check("b2b ready",      32'(mem_ready), 32'd1);
    mem_wsel = 5'd4; mem_alu = 32'h22;
    step();
    mem_valid = 1'b0;
    check("b2b second wen",  32'(rf_WEN), 32'd1);
    check("b2b second wsel", 32'(rf_wsel), 32'd4);
    check("b2b second wdat", rf_wdat, 32'h22);
    check("b2b ready2",      32'(mem_ready), 32'd1);
    step();
    exp_ret = 2;
    check("b2b idle wen", 32'(rf_WEN), 32'd0);
    check("b2b retired",  retired, 32'd2);

    // Signed byte load with delayed data
    mem_valid = 1'b1; mem_regwr = 1'b1; mem_src = 2'b01; mem_wsel = 5'd7;
    mem_ldtype = 2'b10; mem_ldsigned = 1'b1; mem_byteoff = 2'd2;
    step();
    mem_valid = 1'b0;
    check("lb pending", 32'(fwd_pending), 32'd1);
    check("lb fwd_sel", 32'(fwd_sel), 32'd7);
    check("lb ready",   32'(mem_ready), 32'd0);
    check("lb wen",     32'(rf_WEN), 32'd0);
    step();
    step();
    check("lb still pending", 32'(fwd_pending), 32'd1);
    dload_valid = 1'b1; dload = 32'h0080_0000;
    #2;
    check("lb ready on dvalid", 32'(mem_ready), 32'd0);
    step();
    dload_valid = 1'b0;
    check("lb wen",     32'(rf_WEN), 32'd1);
    check("lb wsel",    32'(rf_wsel), 32'd7);
    check("lb wdat",    rf_wdat, 32'hFFFF_FF80);
    check("lb pending cleared", 32'(fwd_pending), 32'd0);
    check("lb ready after", 32'(mem_ready), 32'd1);
    step();
    exp_ret++;
    check("lb retired", retired, 32'(exp_ret));

    // Stray dload_valid while empty
    dload_valid = 1'b1; dload = 32'hDEAD_BEEF;
    step();
    dload_valid = 1'b0;
    check("stray dload wen", 32'(rf_WEN), 32'd0);

    load_op("lhu", 2'b01, 1'b0, 2'd2, 32'hBEEF_1234, 32'h0000_BEEF);
    load_op("lh",  2'b01, 1'b1, 2'd0, 32'h0000_8001, 32'hFFFF_8001);
    load_op("lw",  2'b00, 1'b0, 2'd1, 32'hBEEF_1234, 32'hBEEF_1234);
    load_op("lbu", 2'b10, 1'b0, 2'd3, 32'h9A00_0000, 32'h0000_009A);
    load_op("ld11", 2'b11, 1'b1, 2'd2, 32'h8765_4321, 32'h8765_4321);

    simple_op("lui",  2'b11, 5'd8,  32'h0,  32'h0,   16'hABCD, 1'b1, 32'hABCD_0000);
    simple_op("jal",  2'b10, 5'd31, 32'h0,  32'h104, 16'h0,    1'b1, 32'h0000_0104);
    simple_op("zero", 2'b00, 5'd0,  32'h55, 32'h0,   16'h0,    1'b0, 32'h0000_0055);

    // Halt directly behind an ALU write
    nRST = 1'b0;
    #1;
    check_reset_outputs("reset2");
    nRST = 1'b1;
    mem_valid = 1'b1; mem_regwr = 1'b1; mem_src = 2'b00; mem_wsel = 5'd5; mem_alu = 32'h5A;
    step();
    mem_halt = 1'b1; mem_regwr = 1'b0;
    check("halt prev wen",  32'(rf_WEN), 32'd1);
    check("halt prev wsel", 32'(rf_wsel), 32'd5);
    check("halt prev wdat", rf_wdat, 32'h5A);
    step();
    mem_halt = 1'b0; mem_regwr = 1'b1; mem_wsel = 5'd6; mem_alu = 32'h66;
    check("halt flag",    32'(halt), 32'd1);
    check("halt ready",   32'(mem_ready), 32'd0);
    check("halt wen",     32'(rf_WEN), 32'd0);
    check("halt retired", retired, 32'd2);
    step();
    step();
    mem_valid = 1'b0;
    check("halt sticky",     32'(halt), 32'd1);
    check("halt ignore wen", 32'(rf_WEN), 32'd0);
    check("halt retired2",   retired, 32'd2);

    // Async reset while halted
    #2;
    nRST = 1'b0;
    #1;
    check_reset_outputs("reset halted");
    nRST = 1'b1;

    // Async reset while waiting for load data
    mem_valid = 1'b1; mem_regwr = 1'b1; mem_src = 2'b01; mem_wsel = 5'd9;
    mem_ldtype = 2'b00; mem_ldsigned = 1'b0; mem_byteoff = 2'd0;
    step();
    mem_valid = 1'b0;
    check("rstload pending", 32'(fwd_pending), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    check_reset_outputs("reset waitload");
    nRST = 1'b1;
    dload_valid = 1'b1; dload = 32'h1357_9BDF;
    step();
    dload_valid = 1'b0;
    check("rstload no wen", 32'(rf_WEN), 32'd0);
    check("rstload wdat",   rf_wdat, 32'd0);
    step();
    check("rstload retired", retired, 32'd0);

    exp_ret = 0;
    simple_op("post reset", 2'b00, 5'd10, 32'h77, 32'h0, 16'h0, 1'b1, 32'h0000_0077);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the CPU: accepts completed instructions from the MEM stage over a valid/ready handshake and holds them in the MEM/WB latch. It waits for load data when required, formats loads and LUI/link results, and drives the register file write port (WEN/wsel/wdat). It also gives decode a pending-write indication for hazard stalls, and tracks retired instructions and the sticky halt.

## Interface
- DATA_W, 32, datapath width (fixed at 32; other values unsupported)
- ADDR_W, 5, register select width
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- mem_valid  in  1  MEM stage presents an instruction
- mem_ready  out  1  WB accepts this cycle
- mem_regwr  in  1  instruction writes a register
- mem_wsel  in  ADDR_W  destination register (31 for JAL, supplied by MEM)
- mem_src  in  2  result source: 00 ALU, 01 load, 10 link (pc4), 11 LUI
- mem_alu  in  32  ALU result
- mem_pc4  in  32  PC+4
- mem_imm16  in  16  immediate for LUI
- mem_ldtype  in  2  00 word, 01 half, 10 byte (11 treated as word)
- mem_ldsigned  in  1  sign-extend sub-word load
- mem_byteoff  in  2  address bits [1:0] of load
- mem_halt  in  1  halt instruction
- dload_valid  in  1  data memory load word valid
- dload  in  32  raw load word, little-endian byte lanes
- rf_WEN  out  1  register file write enable
- rf_wsel  out  ADDR_W  register file write select
- rf_wdat  out  32  register file write data
- fwd_pending  out  1  load in WB still waiting with a real destination
- fwd_sel  out  ADDR_W  destination of the pending load
- halt  out  1  sticky halt
- retired  out  32  retired-instruction counter

## Operation
- States: EMPTY, VALID, WAIT_LOAD, HALTED. Latch fields: regwr, wsel, data, ldtype, ldsigned, byteoff.
- mem_ready = (state == EMPTY or VALID). It is combinational from state only and never depends on mem_valid.
- Accept = mem_valid && mem_ready at a rising edge.
- On accept with mem_halt: go to HALTED. No register write.
- On accept with mem_src=01: go to WAIT_LOAD and latch format fields.
- On any other accept: go to VALID and latch data. Data is mem_alu (00), mem_pc4 (10), or {mem_imm16,16'h0} (11).
- VALID without accept: go to EMPTY. VALID with accept follows the accept rules above; the current entry retires on the same edge.
- WAIT_LOAD with dload_valid: latch the formatted dload and go to VALID. WAIT_LOAD without dload_valid: hold.
- HALTED: exits only via reset.
- Load format:
  - word: dload.
  - half: byteoff[1]=0 gives dload[15:0]; byteoff[1]=1 gives dload[31:16]. byteoff[0] is ignored.
  - byte: dload[8k+7:8k] with k=byteoff.
  - Sub-word results are sign-extended if ldsigned, else zero-extended.
- rf_WEN = (state==VALID) && regwr && (wsel != 0). rf_wsel and rf_wdat always reflect the latch.
- fwd_pending = (state==WAIT_LOAD) && regwr && (wsel != 0). fwd_sel = latched wsel.
- retired increments by 1 on each edge that leaves VALID (to any state) and on the edge entering HALTED. It wraps from FFFFFFFF to 0.
- halt = (state==HALTED).

## Timing
- Reset (async, immediate):
  - State goes to EMPTY and all latch fields clear.
  - rf_WEN=0, rf_wsel=0, rf_wdat=0, fwd_pending=0, fwd_sel=0, halt=0, retired=0, mem_ready=1.
- Reset mid-load or mid-halt discards the entry; no write occurs.
- Non-load latency: accepted at edge N, rf_WEN high during cycle N..N+1, register file written at edge N+1.
- Load latency: dload_valid high in cycle M, rf_WEN high in cycle M+1, written at edge M+2. mem_ready is 0 from the accept edge until the edge that samples dload_valid.
- dload_valid outside WAIT_LOAD is ignored.
- Throughput: one non-load instruction per cycle.
- Halt: halt=1 the cycle after acceptance. Any preceding VALID entry writes before that edge. mem_ready=0 thereafter.
- Writes to $0 are suppressed but still count as retired.

## Test plan
- Reset, then ALU writes: back-to-back mem_valid for wsel=3 (alu=0x11) and wsel=4 (alu=0x22). Required: rf_WEN on consecutive cycles with (3,0x11) then (4,0x22); retired=2; mem_ready constantly 1.
- Load with delay: lb signed, byteoff=2, dload=0x00800000, dload_valid raised 3 cycles after accept. Required: fwd_pending=1 with fwd_sel=wsel while waiting; mem_ready=0; then rf_wdat=0xFFFFFF80 one cycle after dload_valid.
- Load formats:
  - lhu, byteoff=2, dload=0xBEEF1234 → 0x0000BEEF.
  - lh, byteoff=0, dload=0x00008001 → 0xFFFF8001.
  - lw → 0xBEEF1234.
- LUI/link/$0:
  - LUI imm=0xABCD → 0xABCD0000.
  - JAL pc4=0x104, wsel=31 → write (31,0x104).
  - ALU to wsel=0 → rf_WEN=0, retired still increments.
- Halt: ALU write to wsel=5, then halt on the next cycle. Required: wsel=5 written, halt=1 the following cycle, mem_ready=0, mem_valid ignored afterwards, retired=2.
- Async reset asserted during WAIT_LOAD and while halted. Required: all outputs at reset values immediately, no write when dload_valid arrives later, and normal accept after nRST deasserts.
